pad_debounce: RTL and testbench

//   Input-side companion to the LED drive path: conditions one raw Fomu user pad or button into a clean level.
//   - Pipeline: 2-flop synchroniser, then a debounce FSM, then 1-cycle press/release event strobes.
//   - Placement: sits between the pad pin and the top-level logic.
//   - Use: the top level uses the strobes to step colours or timer modes.

---
 rtl/pad_debounce_pkg.sv | 20 ++
 rtl/pad_debounce_sync_2ff.sv | 27 ++
 rtl/pad_debounce.sv | 153 +++++++++++++++
 tb/tb_pad_debounce.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pad_debounce_pkg.sv
// Shared types and 48 MHz defaults for the pad debounce slice.
// Long-press detection is enabled by defining PAD_LONG_PRESS_EN.
package pad_debounce_pkg;

  typedef enum logic [1:0] {
    StReleased   = 2'd0,
    StChkPress   = 2'd1,
    StPressed    = 2'd2,
    StChkRelease = 2'd3
  } pad_state_e;

  localparam int unsigned DefClkFreq        = 48_000_000;
  localparam int unsigned DefDebounceCycles = 480_000;
  localparam int unsigned DefHoldCycles     = 48_000_000;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pad_debounce_sync_2ff.sv
// Two-flop synchroniser with asynchronous reset to a selectable level.
// Used by pad_debounce to bring the raw pad into the i_clk domain.
module sync_2ff #(
  parameter bit RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pad_debounce.sv
// Conditions a raw pad into a debounced level plus press/release (and optional long-press) strobes.
// Define PAD_LONG_PRESS_EN to build the hold counter and drive o_long.
module pad_debounce
  import pad_debounce_pkg::*;
#(
  parameter int unsigned CLK_FREQ        = DefClkFreq,
  parameter int unsigned DEBOUNCE_CYCLES = CLK_FREQ / 100,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned HOLD_CYCLES     = CLK_FREQ
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pad,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long
);

  localparam int unsigned    CntW    = $clog2(max_u(DEBOUNCE_CYCLES, HOLD_CYCLES) + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] CntMax  = {CntW{1'b1}};

  logic w_pad_sync;
  logic w_s;

  // Reset the synchroniser to the idle pad level so no press is seen after reset.
  sync_2ff #(
    .RESET_VAL(ACTIVE_LOW)
  ) u_sync (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_d  (i_pad),
    .o_q  (w_pad_sync)
  );

  assign w_s = ACTIVE_LOW ? ~w_pad_sync : w_pad_sync;

  pad_state_e      r_state, w_state_next;
  logic [CntW-1:0] r_cnt, w_cnt_next;
  logic            r_level, w_level_next;
  logic            r_press, w_press_next;
  logic            r_release, w_release_next;
  logic [CntW-1:0] w_cnt_inc;

  assign w_cnt_inc = (r_cnt == CntMax) ? r_cnt : r_cnt + 1'b1;

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_level_next   = r_level;
    w_press_next   = 1'b0;
    w_release_next = 1'b0;
    unique case (r_state)
      StReleased: begin
        if (w_s) begin
          w_state_next = StChkPress;
          w_cnt_next   = CntW'(1);
        end
      end
      StChkPress: begin
        if (!w_s) begin
          w_state_next = StReleased;
          w_cnt_next   = '0;
        end else if (r_cnt == CntLast) begin
          w_state_next = StPressed;
          w_cnt_next   = '0;
          w_level_next = 1'b1;
          w_press_next = 1'b1;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      StPressed: begin
        if (!w_s) begin
          w_state_next = StChkRelease;
          w_cnt_next   = CntW'(1);
        end
      end
      StChkRelease: begin
        if (w_s) begin
          w_state_next = StPressed;
          w_cnt_next   = '0;
        end else if (r_cnt == CntLast) begin
          w_state_next   = StReleased;
          w_cnt_next     = '0;
          w_level_next   = 1'b0;
          w_release_next = 1'b1;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      default: begin
        w_state_next = StReleased;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= StReleased;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_level   <= w_level_next;
      r_press   <= w_press_next;
      r_release <= w_release_next;
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;

`ifdef PAD_LONG_PRESS_EN
  localparam logic [CntW-1:0] HoldLimit = CntW'(HOLD_CYCLES - DEBOUNCE_CYCLES);

  logic [CntW-1:0] r_hold, w_hold_next;
  logic            r_long, w_long_next;

  // Hold count freezes in StChkRelease and saturates at HoldLimit, giving one pulse per press.
  always_comb begin
    w_hold_next = r_hold;
    w_long_next = 1'b0;
    if (r_state == StChkPress && w_state_next == StPressed) begin
      w_hold_next = '0;
    end else if (r_state == StPressed && w_s && r_hold < HoldLimit) begin
      w_hold_next = r_hold + 1'b1;
      w_long_next = (r_hold == HoldLimit - 1'b1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hold <= '0;
      r_long <= 1'b0;
    end else begin
      r_hold <= w_hold_next;
      r_long <= w_long_next;
    end
  end

  assign o_long = r_long;
`else
  assign o_long = 1'b0;
`endif

endmodule

// File: tb/tb_pad_debounce.sv
// Self-checking bench for pad_debounce: directed scenarios plus random pad activity
// compared cycle by cycle against a run-length reference model.
module tb_pad_debounce;

  localparam int unsigned D = 4;
  localparam int unsigned H = 16;

  logic clk = 1'b0;
  logic rst;
  logic pad;
  logic level, press, release_s, long_s;

  always #5 clk = ~clk;

  pad_debounce #(
    .CLK_FREQ       (48_000_000),
    .DEBOUNCE_CYCLES(D),
    .ACTIVE_LOW     (1'b1),
    .HOLD_CYCLES    (H)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_pad    (pad),
    .o_level  (level),
    .o_press  (press),
    .o_release(release_s),
    .o_long   (long_s)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model: pressed-ness seen two edges late; the level flips once the
  // opposite value has been seen for D consecutive edges.
  bit m_hist[$];
  bit m_level;
  int m_run;
  int m_hold;
  bit e_press, e_release, e_long;

  int last_press   = -1;
  int last_release = -1;
  int last_long    = -1;
  int n_press_seen = 0;
  int n_rel_seen   = 0;
  int n_long_seen  = 0;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs == exp) n_pass++;
    else $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
  endtask

  task automatic model_reset();
    m_hist    = {1'b1, 1'b1};
    m_level   = 1'b0;
    m_run     = 0;
    m_hold    = 0;
    e_press   = 1'b0;
    e_release = 1'b0;
    e_long    = 1'b0;
  endtask

  task automatic model_edge(input bit p);
    bit s;
    bit stable_pressed;
    s = !m_hist.pop_front();
    m_hist.push_back(p);
    e_press        = 1'b0;
    e_release      = 1'b0;
    e_long         = 1'b0;
    stable_pressed = m_level && (m_run == 0);
    if (s != m_level) m_run++;
    else m_run = 0;
`ifdef PAD_LONG_PRESS_EN
    if (stable_pressed && s && m_hold < int'(H - D)) begin
      m_hold++;
      if (m_hold == int'(H - D)) e_long = 1'b1;
    end
`endif
    if (m_run == int'(D)) begin
      m_level = !m_level;
      m_run   = 0;
      if (m_level) begin
        e_press = 1'b1;
        m_hold  = 0;
      end else begin
        e_release = 1'b1;
      end
    end
  endtask

  task automatic step(input logic p);
    pad = p;
    @(posedge clk);
    cyc++;
    model_edge(p);
    @(negedge clk);
    if (press)     begin last_press   = cyc; n_press_seen++; end
    if (release_s) begin last_release = cyc; n_rel_seen++;   end
    if (long_s)    begin last_long    = cyc; n_long_seen++;  end
    check_bit("level",   level,     m_level);
    check_bit("press",   press,     e_press);
    check_bit("release", release_s, e_release);
    check_bit("long",    long_s,    e_long);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    pad = 1'b1;
    #1;
    model_reset();
    check_bit("rst_level",   level,     1'b0);
    check_bit("rst_press",   press,     1'b0);
    check_bit("rst_release", release_s, 1'b0);
    check_bit("rst_long",    long_s,    1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int t;
    int np;
    int nl;
    rst = 1'b0;
    pad = 1'b1;
    model_reset();

    // 1: reset, idle pad
    do_reset();
    repeat (20) step(1'b1);
    check_int("idle_press_count", n_press_seen, 0);

    // 2: clean press
    t = cyc;
    repeat (12) step(1'b0);
    check_int("press_latency", last_press, t + 6);
    check_bit("press_level", level, 1'b1);

    // 4: clean release
    t = cyc;
    repeat (12) step(1'b1);
    check_int("release_latency", last_release, t + 6);
    check_bit("release_level", level, 1'b0);

    // 3: glitch reject
    np = n_press_seen;
    repeat (3) step(1'b0);
    repeat (12) step(1'b1);
    check_int("glitch_press_count", n_press_seen, np);

    // 4b: bounce before settling low
    np = n_press_seen;
    step(1'b0); step(1'b0); step(1'b1); step(1'b1);
    repeat (14) step(1'b0);
    check_int("bounce_press_count", n_press_seen, np + 1);
    repeat (12) step(1'b1);

    // 5: reset two cycles into the press check
    np = n_press_seen;
    repeat (4) step(1'b0);
    do_reset();
    repeat (10) step(1'b1);
    check_int("rst_mid_press_count", n_press_seen, np);
    t = cyc;
    repeat (12) step(1'b0);
    check_int("post_rst_press_latency", last_press, t + 6);
    repeat (12) step(1'b1);

    // 6: long hold
    nl = n_long_seen;
    t  = cyc;
    repeat (40) step(1'b0);
    check_int("long_press_latency", last_press, t + 6);
`ifdef PAD_LONG_PRESS_EN
    check_int("long_latency", last_long, t + 18);
    check_int("long_count", n_long_seen, nl + 1);
`else
    check_int("long_count", n_long_seen, nl);
`endif
    repeat (12) step(1'b1);

    // Random pad activity with occasional resets
    for (int seg = 0; seg < 250; seg++) begin
      int len;
      logic v;
      v   = logic'($urandom_range(0, 1));
      len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 30))
                                        : int'($urandom_range(1, 7));
      if ($urandom_range(0, 49) == 0) do_reset();
      for (int k = 0; k < len; k++) step(v);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
